// File: rtl/up_down_pulse_gen.sv
// Push-button front end for the 0-7 up/down counter: per-button synchronizer and
// debouncer feeding a shared press FSM that emits single-cycle up/down pulses with auto-repeat.

module up_down_pulse_gen_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic db
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Any cycle where the synchronized level agrees with db restarts the stability count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (sync2 == db) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt <= '0;
      db  <= ~db;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

module up_down_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic EN,
  input  logic btn_up,
  input  logic btn_down,
  output logic up,
  output logic down,
  output logic lock
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD_UP = 2'd1,
    HOLD_DN = 2'd2,
    LOCK    = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          db_up;
  logic          db_dn;

  up_down_pulse_gen_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk (clk),
    .rst (rst),
    .btn (btn_up),
    .db  (db_up)
  );

  up_down_pulse_gen_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk (clk),
    .rst (rst),
    .btn (btn_down),
    .db  (db_dn)
  );

  // Timer value 1 fires a repeat; 0 parks the timer so REPEAT_DELAY=0 disables repeat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
      up    <= 1'b0;
      down  <= 1'b0;
      lock  <= 1'b0;
    end else begin
      up   <= 1'b0;
      down <= 1'b0;
      case (state)
        IDLE: begin
          if (EN) begin
            if (db_up && db_dn) begin
              state <= LOCK;
              lock  <= 1'b1;
            end else if (db_up) begin
              up    <= 1'b1;
              state <= HOLD_UP;
              timer <= TW'(REPEAT_DELAY);
            end else if (db_dn) begin
              down  <= 1'b1;
              state <= HOLD_DN;
              timer <= TW'(REPEAT_DELAY);
            end
          end
        end
        HOLD_UP: begin
          if (!db_up) begin
            state <= IDLE;
          end else if (db_dn || !EN) begin
            state <= LOCK;
            lock  <= 1'b1;
          end else if (timer == TW'(1)) begin
            up    <= 1'b1;
            timer <= TW'(REPEAT_RATE);
          end else if (timer != '0) begin
            timer <= timer - 1'b1;
          end
        end
        HOLD_DN: begin
          if (!db_dn) begin
            state <= IDLE;
          end else if (db_up || !EN) begin
            state <= LOCK;
            lock  <= 1'b1;
          end else if (timer == TW'(1)) begin
            down  <= 1'b1;
            timer <= TW'(REPEAT_RATE);
          end else if (timer != '0) begin
            timer <= timer - 1'b1;
          end
        end
        LOCK: begin
          if (!db_up && !db_dn) begin
            state <= IDLE;
            lock  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          lock  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_up_down_pulse_gen.sv
// Bench for up_down_pulse_gen: expected pulses (direction + cycle) are queued when
// buttons are driven and matched against every pulse the DUT emits.

module tb_up_down_pulse_gen;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;
  localparam int LAT = DB + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b1;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic up;
  logic down;
  logic lock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [31:0] want;

  up_down_pulse_gen #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .EN       (en),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .up       (up),
    .down     (down),
    .lock     (lock)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ev(input logic dir, input int c);
    logic [31:0] cc;
    cc = c;
    return {dir, cc[30:0]};
  endfunction

  // scoreboard: every pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (up && down) begin
      checks++;
      errors++;
      $display("FAIL both_pulses cyc=%0d up=%0b down=%0b required one-hot", cyc, up, down);
    end
    if (up || down) begin
      got = ev(down, cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse dir=%0d cyc=%0d required no pulse", down, cyc);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL pulse_match got dir=%0d cyc=%0d required dir=%0d cyc=%0d",
                   got[31], got[30:0], want[31], want[30:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    int b;
    b = 0;
    while (cyc < t && b < 1000) begin
      @(negedge clk);
      b++;
    end
    checks++;
    if (cyc !== t) begin
      errors++;
      $display("FAIL wait_until cyc=%0d required %0d", cyc, t);
    end
  endtask

  task automatic drain(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_pulses left=%0d required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    en = 1'b1;
    #2;
    checks++;
    if ({up, down, lock} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got %b required 000", {up, down, lock});
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({up, down, lock} !== 3'b000) begin
        errors++;
        $display("FAIL idle_outputs cyc=%0d got %b required 000", cyc, {up, down, lock});
      end
    end
    drain("reset");
  endtask

  task automatic test_single_up();
    int n;
    @(negedge clk);
    n = cyc;
    btn_up = 1'b1;
    exp_q.push_back(ev(1'b0, n + LAT));
    wait_until(n + 10);
    btn_up = 1'b0;
    tick(15);
    checks++;
    if (lock !== 1'b0) begin
      errors++;
      $display("FAIL single_up_lock got %b required 0", lock);
    end
    drain("single_up");
  endtask

  task automatic test_bounce();
    int n;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      btn_down = (i % 2 == 0);
      tick(2);
    end
    btn_down = 1'b0;
    tick(10);
    drain("bounce_glitch");
    n = cyc;
    btn_down = 1'b1;
    exp_q.push_back(ev(1'b1, n + LAT));
    tick(8);
    btn_down = 1'b0;
    tick(15);
    drain("bounce_clean");
  endtask

  task automatic test_repeat();
    int n;
    int p;
    @(negedge clk);
    n = cyc;
    p = n + LAT;
    btn_up = 1'b1;
    exp_q.push_back(ev(1'b0, p));
    for (int k = 0; k < 5; k++) exp_q.push_back(ev(1'b0, p + RD + k * RR));
    // released so the debounced drop lands exactly before the would-be pulse at p+60
    wait_until(n + 60);
    btn_up = 1'b0;
    tick(20);
    drain("repeat");
  endtask

  task automatic test_lock();
    int n;
    int m;
    int r;
    @(negedge clk);
    n = cyc;
    btn_up = 1'b1;
    exp_q.push_back(ev(1'b0, n + LAT));
    wait_until(n + 12);
    m = cyc;
    btn_down = 1'b1;
    wait_until(m + 6);
    checks++;
    if (lock !== 1'b0) begin
      errors++;
      $display("FAIL lock_before got %b required 0", lock);
    end
    tick(1);
    checks++;
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL lock_enter got %b required 1", lock);
    end
    tick(20);
    checks++;
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL lock_hold got %b required 1", lock);
    end
    r = cyc;
    btn_up = 1'b0;
    btn_down = 1'b0;
    wait_until(r + 6);
    checks++;
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL lock_release_early got %b required 1", lock);
    end
    tick(1);
    checks++;
    if (lock !== 1'b0) begin
      errors++;
      $display("FAIL lock_exit got %b required 0", lock);
    end
    tick(10);
    drain("lock");
  endtask

  task automatic test_enable();
    int n;
    int r;
    int m;
    @(negedge clk);
    n = cyc;
    btn_up = 1'b1;
    exp_q.push_back(ev(1'b0, n + LAT));
    wait_until(n + 12);
    en = 1'b0;
    tick(1);
    checks++;
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL en_low_lock got %b required 1", lock);
    end
    tick(10);
    en = 1'b1;
    tick(30);
    checks++;
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL en_high_held_lock got %b required 1", lock);
    end
    r = cyc;
    btn_up = 1'b0;
    wait_until(r + 7);
    checks++;
    if (lock !== 1'b0) begin
      errors++;
      $display("FAIL en_release_lock got %b required 0", lock);
    end
    tick(3);
    m = cyc;
    btn_up = 1'b1;
    exp_q.push_back(ev(1'b0, m + LAT));
    tick(10);
    btn_up = 1'b0;
    tick(15);
    drain("enable");
  endtask

  task automatic test_reset_mid();
    int n;
    int k;
    @(negedge clk);
    n = cyc;
    btn_up = 1'b1;
    exp_q.push_back(ev(1'b0, n + LAT));
    wait_until(n + LAT);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({up, down, lock} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_async got %b required 000", {up, down, lock});
    end
    tick(4);
    k = cyc;
    rst = 1'b1;
    exp_q.push_back(ev(1'b0, k + LAT));
    tick(10);
    btn_up = 1'b0;
    tick(15);
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_bounce();
    test_repeat();
    test_lock();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
